// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel UART transmit stage.
// Holds the transmit FSM state enum, UART frame constants and the baud divider helper.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

  function automatic int baud_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sobel_sync_fifo.sv
// Small synchronous FIFO with registered count/full/empty.
// Read data is registered at the pop edge and is valid in the following cycle.
module sobel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_rd_data;
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/sobel_uart_tx.sv
// Buffers the Sobel gradient byte stream and serialises it as 8N1 UART frames.
// Optional binarisation at write time is enabled by defining SOBEL_TX_THRESH_EN.
module sobel_uart_tx
  import sobel_pkg::*;
#(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 9600,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] THRESH     = 8'd128
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int BCM = baud_cnt_max(CLK_FREQ, BAUD);
  localparam int CW  = (BCM > 1) ? $clog2(BCM) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int BIW = $clog2(UART_DATA_BITS);

`ifdef SOBEL_TX_THRESH_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  tx_state_t                 r_state;
  tx_state_t                 w_state_next;
  logic [CW-1:0]             r_baud_cnt;
  logic [BIW-1:0]            r_bit_idx;
  logic [BIW-1:0]            w_bit_idx_next;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_next;
  logic                      r_tx;
  logic                      w_tx_next;
  logic                      r_overflow;
  logic                      w_bit_end;
  logic                      w_pop;
  logic [7:0]                w_wr_data;
  logic [7:0]                w_rd_data;
  logic [FCW-1:0]            w_count;
  logic                      w_full;
  logic                      w_empty;

  assign w_wr_data = THRESH_EN ? ((pi_data >= THRESH) ? 8'hFF : 8'h00) : pi_data;
  assign w_bit_end = (r_baud_cnt == CW'(BCM - 1));
  assign tx        = r_tx;
  assign overflow  = r_overflow;
  assign busy      = (r_state != ST_IDLE) || (w_count != '0);

  sobel_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (sys_clk),
    .i_rst     (sys_rst),
    .i_wr_en   (pi_flag && !w_full),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // The popped byte lands in w_rd_data one cycle later, so it is loaded at the end of START.
  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_shift_next   = w_rd_data;
          w_bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == BIW'(UART_DATA_BITS - 1)) begin
            w_state_next = ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    case (w_state_next)
      ST_START: w_tx_next = UART_START_BIT;
      ST_DATA:  w_tx_next = w_shift_next[0];
      default:  w_tx_next = UART_STOP_BIT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= UART_STOP_BIT;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_overflow <= r_overflow | (pi_flag & w_full);
      if (r_state == ST_IDLE || w_bit_end) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end
  end

endmodule
